hamming_decoder: RTL
====================

HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 SHALL have parameter: CNT_W, default 8, width of the corrected-error counter.
REQ-002 SHALL have port: clk_dec  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port: rst_dec  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port: codeword_in  input  7 [7:1]  Hamming(7,4) codeword, parity bits at positions 1, 2 and 4, data bits at positions 3, 5, 6 and 7.
REQ-005 SHALL have port: cw_valid  input  1  codeword_in is valid this cycle.
REQ-006 SHALL have port: cw_ready  output  1  decoder accepts codeword_in this cycle.
REQ-007 SHALL have port: dec_data  output  4 [4:1]  corrected data {c7,c6,c5,c3}.
REQ-008 SHALL have port: dec_valid  output  1  dec_data, err_flag and err_pos are valid.
REQ-009 SHALL have port: dec_ready  input  1  downstream accepts the output this cycle.
REQ-010 SHALL have port: err_flag  output  1  a single-bit error was corrected in this word.
REQ-011 SHALL have port: err_pos  output  3  error position from the syndrome (1..7), 0 when no error.
REQ-012 SHALL have port: err_cnt_clr  input  1  synchronous clear of err_cnt.
REQ-013 SHALL have port: err_cnt  output  CNT_W  saturating count of corrected words.

Function
REQ-014 Syndrome bits SHALL be: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s4=c4^c5^c6^c7, with syndrome={s4,s2,s1}.
REQ-015 A nonzero syndrome SHALL invert codeword bit [syndrome] before data extraction; a zero syndrome SHALL leave the codeword unchanged.
REQ-016 Decoding SHALL be a 2-stage elastic pipeline: S1 registers the codeword and syndrome; S2 registers dec_data, err_flag and err_pos.
REQ-017 A transfer SHALL occur on a rising edge where valid and ready are both 1; the handshake SHALL apply on both input and output.
REQ-018 S2 SHALL be able to load when !dec_valid || dec_ready; S1 SHALL be able to load when !S1_valid || S2 can load; cw_ready SHALL equal the S1 load condition.
REQ-019 Latency SHALL be 2 cycles from input transfer to dec_valid with no stall; sustained throughput SHALL be 1 word per cycle while dec_ready=1.
REQ-020 While dec_ready=0 and dec_valid=1, dec_data, err_flag and err_pos SHALL be held stable; no accepted word SHALL be dropped or duplicated.
REQ-021 A codeword offered while cw_ready=0 SHALL NOT be captured.
REQ-022 A double-bit error SHALL be miscorrected as a single-bit error; detecting it is out of scope.
REQ-023 err_flag SHALL be 1 exactly when err_pos != 0.

Reset
REQ-024 On rst_dec=0, S1_valid, dec_valid, dec_data, err_flag, err_pos and err_cnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight words.
REQ-026 cw_ready SHALL be 1 from the first cycle after reset deassertion.

Configuration
REQ-027 With macro HAMMING_DEC_ERRCNT_EN defined, err_cnt SHALL increment by 1 on each output transfer with err_flag=1.
REQ-028 With HAMMING_DEC_ERRCNT_EN defined, err_cnt SHALL saturate at 2^CNT_W-1.
REQ-029 With HAMMING_DEC_ERRCNT_EN defined, err_cnt_clr=1 SHALL set err_cnt to 0 and SHALL take priority over a simultaneous increment.
REQ-030 With HAMMING_DEC_ERRCNT_EN undefined, err_cnt SHALL be constant 0, err_cnt_clr SHALL be ignored, and no counter register SHALL exist.

Verification
REQ-031 Clean word: codeword_in=7'b1010101 with cw_valid=1 and dec_ready=1 -> 2 cycles later dec_valid=1, dec_data=4'b1011, err_flag=0, err_pos=0.
REQ-032 Data-bit error: codeword_in=7'b1000101 (bit 5 flipped) -> dec_data=4'b1011, err_flag=1, err_pos=5, err_cnt 0->1 (macro on).
REQ-033 Parity-bit error: codeword_in=7'b1011101 (bit 4 flipped) -> dec_data=4'b1011, err_pos=4.
REQ-034 Backpressure: stream 4 words with dec_ready=0 for cycles 3-6 -> cw_ready=0 once both stages are full, outputs held stable, all 4 words delivered in order.
REQ-035 Counter: CNT_W=2 with 5 erroneous words -> err_cnt saturates at 3; err_cnt_clr asserted together with an erroneous output transfer -> err_cnt=0.
REQ-036 Reset: rst_dec=0 while 2 words are in flight -> dec_valid=0 and err_cnt=0 immediately, and neither word appears after release.

Source files
------------

// File: rtl/hamming_decoder.sv
// Hamming(7,4) single-error-correcting decoder, 2-stage elastic pipeline.
// Optional corrected-word counter enabled by HAMMING_DEC_ERRCNT_EN.
module hamming_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk_dec,
   input  logic             rst_dec,
   input  logic [7:1]       codeword_in,
   input  logic             cw_valid,
   output logic             cw_ready,
   output logic [4:1]       dec_data,
   output logic             dec_valid,
   input  logic             dec_ready,
   output logic             err_flag,
   output logic [2:0]       err_pos,
   input  logic             err_cnt_clr,
   output logic [CNT_W-1:0] err_cnt
);

   typedef struct packed {
      logic [7:1] cw;
      logic [2:0] syn;
   } s1_t;

   logic       s1_valid;
   s1_t        s1_q;
   s1_t        s1_d;
   logic       s1_load;
   logic       s2_load;
   logic       out_xfer;
   logic [7:1] fixed;

   assign s2_load  = !dec_valid || dec_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign cw_ready = s1_load;
   assign out_xfer = dec_valid && dec_ready;

   always_comb begin
      s1_d.cw  = codeword_in;
      s1_d.syn = {codeword_in[4] ^ codeword_in[5] ^ codeword_in[6] ^ codeword_in[7],
                  codeword_in[2] ^ codeword_in[3] ^ codeword_in[6] ^ codeword_in[7],
                  codeword_in[1] ^ codeword_in[3] ^ codeword_in[5] ^ codeword_in[7]};
   end

   // syndrome names the failing bit position directly
   always_comb begin
      fixed = s1_q.cw;
      for (int i = 1; i <= 7; i++) begin
         if (s1_q.syn == 3'(i)) fixed[i] = ~s1_q.cw[i];
      end
   end

   always_ff @(posedge clk_dec or negedge rst_dec) begin
      if (!rst_dec) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_load) begin
         s1_valid <= cw_valid;
         if (cw_valid) s1_q <= s1_d;
      end
   end

   always_ff @(posedge clk_dec or negedge rst_dec) begin
      if (!rst_dec) begin
         dec_valid <= 1'b0;
         dec_data  <= '0;
         err_flag  <= 1'b0;
         err_pos   <= '0;
      end else if (s2_load) begin
         dec_valid <= s1_valid;
         if (s1_valid) begin
            dec_data <= {fixed[7], fixed[6], fixed[5], fixed[3]};
            err_flag <= |s1_q.syn;
            err_pos  <= s1_q.syn;
         end
      end
   end

`ifdef HAMMING_DEC_ERRCNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_dec or negedge rst_dec) begin
      if (!rst_dec) begin
         cnt_q <= '0;
      end else if (err_cnt_clr) begin
         cnt_q <= '0;
      end else if (out_xfer && err_flag && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign err_cnt = cnt_q;
`else
   logic unused_cnt;

   assign unused_cnt = err_cnt_clr ^ out_xfer;
   assign err_cnt    = '0;
`endif

endmodule
